// File: rtl/otter_bus_demux.sv
// 1-to-N request router for the OTTER memory-mapped bus; ADDR[31:28] selects the target, one transaction in flight.
// Optional macro BUS_DEMUX_TIMEOUT_EN adds a REQ/WAIT watchdog that answers with an error after TIMEOUT cycles.
module otter_bus_demux #(
    parameter int N_TARGETS = 4,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic [31:0]                   IN_ADDR,
    input  logic                          IN_WE,
    input  logic [3:0]                    IN_BE,
    input  logic [DATA_W-1:0]             IN_WDATA,
    output logic                          IN_RVALID,
    output logic [DATA_W-1:0]             IN_RDATA,
    output logic                          IN_ERR,
    output logic [N_TARGETS-1:0]          T_VALID,
    input  logic [N_TARGETS-1:0]          T_READY,
    output logic [31:0]                   T_ADDR,
    output logic                          T_WE,
    output logic [3:0]                    T_BE,
    output logic [DATA_W-1:0]             T_WDATA,
    input  logic [N_TARGETS-1:0]          T_RVALID,
    input  logic [N_TARGETS*DATA_W-1:0]   T_RDATA
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    state_t                state_r, state_s;
    logic                  in_ready_r, in_ready_s;
    logic                  in_rvalid_r, in_rvalid_s;
    logic                  in_err_r, in_err_s;
    logic [DATA_W-1:0]     in_rdata_r, in_rdata_s;
    logic [N_TARGETS-1:0]  t_valid_r, t_valid_s;
    logic [31:0]           t_addr_r, t_addr_s;
    logic                  t_we_r, t_we_s;
    logic [3:0]            t_be_r, t_be_s;
    logic [DATA_W-1:0]     t_wdata_r, t_wdata_s;
    logic [N_TARGETS-1:0]  sel_oh_r, sel_oh_s;

    logic [N_TARGETS-1:0]  dec_oh_s;
    logic                  in_range_s;
    logic                  sel_ready_s;
    logic                  sel_rvalid_s;
    logic [DATA_W-1:0]     sel_rdata_s;
    logic                  enter_req_s;
    logic                  timeout_s;

    // Target decode from the top address nibble; out-of-range indices give an all-zero vector.
    always_comb begin
        dec_oh_s = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            dec_oh_s[i] = (IN_ADDR[31:28] == 4'(i));
        end
    end

    assign in_range_s   = |dec_oh_s;
    assign sel_ready_s  = |(T_READY & sel_oh_r);
    assign sel_rvalid_s = |(T_RVALID & sel_oh_r);

    // Response data slice of the selected target only.
    always_comb begin
        sel_rdata_s = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (sel_oh_r[i]) begin
                sel_rdata_s = sel_rdata_s | T_RDATA[i*DATA_W +: DATA_W];
            end else begin
                sel_rdata_s = sel_rdata_s;
            end
        end
    end

`ifdef BUS_DEMUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W:0]   cnt_inc_s;

    assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_s = (cnt_inc_s == (CNT_W + 1)'(TIMEOUT));

    // Watchdog: cleared when a request is issued, counts every cycle spent in REQ or WAIT.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_r <= '0;
        end else if (enter_req_s) begin
            cnt_r <= '0;
        end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            cnt_r <= cnt_inc_s[CNT_W-1:0];
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        in_ready_s  = 1'b0;
        in_rvalid_s = 1'b0;
        in_err_s    = 1'b0;
        in_rdata_s  = in_rdata_r;
        t_valid_s   = t_valid_r;
        t_addr_s    = t_addr_r;
        t_we_s      = t_we_r;
        t_be_s      = t_be_r;
        t_wdata_s   = t_wdata_r;
        sel_oh_s    = sel_oh_r;
        enter_req_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (IN_VALID && in_ready_r) begin
                    t_addr_s  = IN_ADDR;
                    t_we_s    = IN_WE;
                    t_be_s    = IN_BE;
                    t_wdata_s = IN_WDATA;
                    sel_oh_s  = dec_oh_s;
                    if (in_range_s) begin
                        state_s     = ST_REQ;
                        t_valid_s   = dec_oh_s;
                        enter_req_s = 1'b1;
                    end else begin
                        state_s     = ST_ERR;
                        t_valid_s   = '0;
                        in_rvalid_s = 1'b1;
                        in_err_s    = 1'b1;
                        in_rdata_s  = ERR_DATA;
                    end
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            ST_REQ: begin
                if (sel_ready_s && sel_rvalid_s) begin
                    state_s     = ST_DONE;
                    t_valid_s   = '0;
                    in_rvalid_s = 1'b1;
                    in_rdata_s  = sel_rdata_s;
                end else if (timeout_s) begin
                    state_s     = ST_ERR;
                    t_valid_s   = '0;
                    in_rvalid_s = 1'b1;
                    in_err_s    = 1'b1;
                    in_rdata_s  = ERR_DATA;
                end else if (sel_ready_s) begin
                    state_s   = ST_WAIT;
                    t_valid_s = '0;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (sel_rvalid_s) begin
                    state_s     = ST_DONE;
                    in_rvalid_s = 1'b1;
                    in_rdata_s  = sel_rdata_s;
                end else if (timeout_s) begin
                    state_s     = ST_ERR;
                    in_rvalid_s = 1'b1;
                    in_err_s    = 1'b1;
                    in_rdata_s  = ERR_DATA;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE, ST_ERR: begin
                state_s    = ST_IDLE;
                in_ready_s = 1'b1;
            end
            default: begin
                state_s   = ST_IDLE;
                t_valid_s = '0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            in_rvalid_r <= 1'b0;
            in_err_r    <= 1'b0;
            in_rdata_r  <= '0;
            t_valid_r   <= '0;
            t_addr_r    <= 32'd0;
            t_we_r      <= 1'b0;
            t_be_r      <= 4'd0;
            t_wdata_r   <= '0;
            sel_oh_r    <= '0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= in_ready_s;
            in_rvalid_r <= in_rvalid_s;
            in_err_r    <= in_err_s;
            in_rdata_r  <= in_rdata_s;
            t_valid_r   <= t_valid_s;
            t_addr_r    <= t_addr_s;
            t_we_r      <= t_we_s;
            t_be_r      <= t_be_s;
            t_wdata_r   <= t_wdata_s;
            sel_oh_r    <= sel_oh_s;
        end
    end

    assign IN_READY  = in_ready_r;
    assign IN_RVALID = in_rvalid_r;
    assign IN_ERR    = in_err_r;
    assign IN_RDATA  = in_rdata_r;
    assign T_VALID   = t_valid_r;
    assign T_ADDR    = t_addr_r;
    assign T_WE      = t_we_r;
    assign T_BE      = t_be_r;
    assign T_WDATA   = t_wdata_r;

endmodule

// File: tb/tb_otter_bus_demux.sv
// Directed bench for otter_bus_demux (4 targets, TIMEOUT=16); follows BUS_DEMUX_TIMEOUT_EN like the design.
`timescale 1ns/1ps
module tb_otter_bus_demux;

    localparam int NT = 4;
    localparam int DW = 32;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic            IN_VALID;
    logic            IN_READY;
    logic [31:0]     IN_ADDR;
    logic            IN_WE;
    logic [3:0]      IN_BE;
    logic [DW-1:0]   IN_WDATA;
    logic            IN_RVALID;
    logic [DW-1:0]   IN_RDATA;
    logic            IN_ERR;
    logic [NT-1:0]   T_VALID;
    logic [NT-1:0]   T_READY;
    logic [31:0]     T_ADDR;
    logic            T_WE;
    logic [3:0]      T_BE;
    logic [DW-1:0]   T_WDATA;
    logic [NT-1:0]   T_RVALID;
    logic [NT*DW-1:0] T_RDATA;

    int checks = 0;
    int failures = 0;

    otter_bus_demux #(.N_TARGETS(NT), .DATA_W(DW), .TIMEOUT(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_ADDR(IN_ADDR), .IN_WE(IN_WE),
        .IN_BE(IN_BE), .IN_WDATA(IN_WDATA), .IN_RVALID(IN_RVALID), .IN_RDATA(IN_RDATA),
        .IN_ERR(IN_ERR), .T_VALID(T_VALID), .T_READY(T_READY), .T_ADDR(T_ADDR),
        .T_WE(T_WE), .T_BE(T_BE), .T_WDATA(T_WDATA), .T_RVALID(T_RVALID), .T_RDATA(T_RDATA)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        IN_VALID = 1'b1;
        IN_ADDR  = addr;
        IN_WE    = we;
        IN_BE    = 4'hF;
        IN_WDATA = wdata;
        step();
        IN_VALID = 1'b0;
        IN_ADDR  = 32'd0;
        IN_WDATA = 32'd0;
    endtask

    initial begin
        logic seen;
        RESET_N  = 1'b0;
        IN_VALID = 1'b0;
        IN_ADDR  = 32'd0;
        IN_WE    = 1'b0;
        IN_BE    = 4'd0;
        IN_WDATA = 32'd0;
        T_READY  = 4'd0;
        T_RVALID = 4'd0;
        T_RDATA  = '0;

        // Reset values
        repeat (3) step();
        check_eq("rst_in_ready", 64'(IN_READY), 64'd0);
        check_eq("rst_in_rvalid", 64'(IN_RVALID), 64'd0);
        check_eq("rst_in_err", 64'(IN_ERR), 64'd0);
        check_eq("rst_in_rdata", 64'(IN_RDATA), 64'd0);
        check_eq("rst_t_valid", 64'(T_VALID), 64'd0);
        check_eq("rst_t_addr", 64'(T_ADDR), 64'd0);
        RESET_N = 1'b1;
        step();
        check_eq("rel_in_ready", 64'(IN_READY), 64'd1);

        // Test 1: write to target 1, ready at once, response one cycle later
        T_READY = 4'b0010;
        issue(32'h1000_0040, 1'b1, 32'hCAFE_F00D);
        check_eq("t1_t_valid", 64'(T_VALID), 64'h2);
        check_eq("t1_t_addr", 64'(T_ADDR), 64'h1000_0040);
        check_eq("t1_t_wdata", 64'(T_WDATA), 64'hCAFE_F00D);
        check_eq("t1_t_we", 64'(T_WE), 64'd1);
        check_eq("t1_t_be", 64'(T_BE), 64'hF);
        check_eq("t1_in_ready_busy", 64'(IN_READY), 64'd0);
        step();
        T_READY = 4'd0;
        check_eq("t1_t_valid_drop", 64'(T_VALID), 64'h0);
        check_eq("t1_no_early_rvalid", 64'(IN_RVALID), 64'd0);
        T_RVALID = 4'b0010;
        step();
        T_RVALID = 4'd0;
        check_eq("t1_in_rvalid", 64'(IN_RVALID), 64'd1);
        check_eq("t1_in_err", 64'(IN_ERR), 64'd0);
        step();
        check_eq("t1_rvalid_one_cycle", 64'(IN_RVALID), 64'd0);
        check_eq("t1_back_idle", 64'(IN_READY), 64'd1);

        // Test 2: read target 2, ready withheld for 3 cycles
        issue(32'h2000_0000, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check_eq("t2_t_valid_hold", 64'(T_VALID), 64'h4);
            check_eq("t2_t_addr_hold", 64'(T_ADDR), 64'h2000_0000);
            step();
        end
        check_eq("t2_t_valid_4th", 64'(T_VALID), 64'h4);
        T_READY = 4'b0100;
        T_RVALID = 4'b0100;
        T_RDATA[2*DW +: DW] = 32'h1234_5678;
        T_RDATA[1*DW +: DW] = 32'hAAAA_AAAA;
        step();
        T_READY = 4'd0;
        T_RVALID = 4'd0;
        check_eq("t2_in_rvalid", 64'(IN_RVALID), 64'd1);
        check_eq("t2_in_rdata", 64'(IN_RDATA), 64'h1234_5678);
        check_eq("t2_in_err", 64'(IN_ERR), 64'd0);
        check_eq("t2_t_valid_off", 64'(T_VALID), 64'h0);
        step();

        // Test 3: decode error
        issue(32'h7000_0000, 1'b0, 32'd0);
        check_eq("t3_in_rvalid", 64'(IN_RVALID), 64'd1);
        check_eq("t3_in_err", 64'(IN_ERR), 64'd1);
        check_eq("t3_in_rdata", 64'(IN_RDATA), 64'hDEAD_BEEF);
        check_eq("t3_t_valid", 64'(T_VALID), 64'h0);
        step();
        check_eq("t3_rvalid_off", 64'(IN_RVALID), 64'd0);
        check_eq("t3_err_off", 64'(IN_ERR), 64'd0);
        check_eq("t3_in_ready", 64'(IN_READY), 64'd1);

        // Test 6: foreign strobes while waiting on target 1
        issue(32'h1000_0008, 1'b0, 32'd0);
        check_eq("t6_t_valid", 64'(T_VALID), 64'h2);
        T_READY = 4'b0010;
        T_RVALID = 4'b0001;
        T_RDATA[0*DW +: DW] = 32'h1111_1111;
        step();
        check_eq("t6_ignore_rv0", 64'(IN_RVALID), 64'd0);
        T_READY = 4'b0100;
        T_RVALID = 4'b0001;
        step();
        check_eq("t6_ignore_rdy2", 64'(IN_RVALID), 64'd0);
        T_READY = 4'd0;
        T_RVALID = 4'b0010;
        T_RDATA[1*DW +: DW] = 32'h55AA_33CC;
        step();
        T_RVALID = 4'd0;
        check_eq("t6_in_rvalid", 64'(IN_RVALID), 64'd1);
        check_eq("t6_in_rdata", 64'(IN_RDATA), 64'h55AA_33CC);
        step();

        // Test 5: asynchronous reset while in WAIT, then zero-wait read of target 0
        issue(32'h2000_0010, 1'b1, 32'h0BAD_F00D);
        T_READY = 4'b0100;
        step();
        T_READY = 4'd0;
        #2;
        RESET_N = 1'b0;
        #1;
        check_eq("t5_async_t_addr", 64'(T_ADDR), 64'd0);
        check_eq("t5_async_t_wdata", 64'(T_WDATA), 64'd0);
        check_eq("t5_async_t_we", 64'(T_WE), 64'd0);
        check_eq("t5_async_in_ready", 64'(IN_READY), 64'd0);
        check_eq("t5_async_t_valid", 64'(T_VALID), 64'd0);
        step();
        RESET_N = 1'b1;
        T_RVALID = 4'b0100;
        step();
        T_RVALID = 4'd0;
        check_eq("t5_stale_ignored", 64'(IN_RVALID), 64'd0);
        check_eq("t5_in_ready", 64'(IN_READY), 64'd1);
        issue(32'h0000_0100, 1'b0, 32'd0);
        check_eq("t5_t_valid", 64'(T_VALID), 64'h1);
        T_READY = 4'b0001;
        T_RVALID = 4'b0001;
        T_RDATA[0*DW +: DW] = 32'hA5A5_0F0F;
        step();
        T_READY = 4'd0;
        T_RVALID = 4'd0;
        check_eq("t5_in_rvalid", 64'(IN_RVALID), 64'd1);
        check_eq("t5_in_rdata", 64'(IN_RDATA), 64'hA5A5_0F0F);
        step();

        // Test 4: target 3 never ready
        issue(32'h3000_0000, 1'b0, 32'd0);
        seen = 1'b0;
`ifdef BUS_DEMUX_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            seen = seen | IN_RVALID;
            if (k == 16) begin
                check_eq("t4_t_valid_last", 64'(T_VALID), 64'h8);
            end
            step();
        end
        check_eq("t4_no_early_resp", 64'(seen), 64'd0);
        check_eq("t4_to_rvalid", 64'(IN_RVALID), 64'd1);
        check_eq("t4_to_err", 64'(IN_ERR), 64'd1);
        check_eq("t4_to_rdata", 64'(IN_RDATA), 64'hDEAD_BEEF);
        check_eq("t4_to_t_valid", 64'(T_VALID), 64'h0);
        T_READY = 4'b1000;
        T_RVALID = 4'b1000;
        step();
        T_READY = 4'd0;
        T_RVALID = 4'd0;
        check_eq("t4_late_ignored", 64'(IN_RVALID), 64'd0);
        check_eq("t4_in_ready", 64'(IN_READY), 64'd1);
`else
        for (int k = 0; k < 100; k++) begin
            seen = seen | IN_RVALID;
            step();
        end
        check_eq("t4_no_resp", 64'(seen), 64'd0);
        check_eq("t4_t_valid_held", 64'(T_VALID), 64'h8);
        T_READY = 4'b1000;
        T_RVALID = 4'b1000;
        T_RDATA[3*DW +: DW] = 32'h3333_0003;
        step();
        T_READY = 4'd0;
        T_RVALID = 4'd0;
        check_eq("t4_late_rvalid", 64'(IN_RVALID), 64'd1);
        check_eq("t4_late_rdata", 64'(IN_RDATA), 64'h3333_0003);
        check_eq("t4_late_err", 64'(IN_ERR), 64'd0);
        step();
        check_eq("t4_in_ready", 64'(IN_READY), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
